full_adder_cascading: RTL and testbench



---
 rtl/fac_pkg.sv | 15 +
 rtl/fac_cell.sv | 19 +
 rtl/full_adder_cascading.sv | 77 +++++++
 tb/tb_full_adder_cascading.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fac_pkg.sv
// Shared definitions for the cascading full-adder datapath primitive.
// Optional carry-in feature is controlled by the FAC_CARRY_IN_EN macro.
package fac_pkg;

    localparam int FAC_DEFAULT_WIDTH = 1;
    localparam int FAC_MAX_WIDTH     = 64;

    // Widest possible {carry, sum} record; the top declares a WIDTH-sized
    // copy of the same layout for its result register.
    typedef struct packed {
        logic                     carry;
        logic [FAC_MAX_WIDTH-1:0] sum;
    } fac_result_max_t;

endpackage : fac_pkg

// File: rtl/fac_cell.sv
// 1-bit full-adder cell: the unit the ripple chain is built from.
module fac_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term shared by the sum and the carry-out.
    always_comb begin
        p    = a ^ b;
        s    = p ^ cin;
        cout = (a & b) | (cin & p);
    end

endmodule : fac_cell

// File: rtl/full_adder_cascading.sv
// Registered ripple-carry adder built from WIDTH cascaded fac_cell instances.
// Define FAC_CARRY_IN_EN to add carry-in port Z; otherwise cell 0 carry-in is 0.
module full_adder_cascading
    import fac_pkg::*;
#(
    parameter int WIDTH = FAC_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef FAC_CARRY_IN_EN
    input  logic             Z,
`endif
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             valid_out
);

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] sum;
    } fac_result_t;

    logic [WIDTH:0]   carry_w;
    logic [WIDTH-1:0] sum_w;

    fac_result_t result_d, result_q;
    logic        valid_d,  valid_q;

`ifdef FAC_CARRY_IN_EN
    assign carry_w[0] = Z;
`else
    assign carry_w[0] = 1'b0;
`endif

    // Ripple chain: each cell's carry-out feeds the next cell's carry-in.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fac_cell u_cell (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry_w[i]),
            .s    (sum_w[i]),
            .cout (carry_w[i+1])
        );
    end

    // Load a new result on valid input, otherwise hold it; valid follows valid_in.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        result_d = result_q;
        valid_d  = 1'b0;
        if (valid_in) begin
            result_d.carry = carry_w[WIDTH];
            result_d.sum   = sum_w;
            valid_d        = 1'b1;
        end
    end

    // Output and valid registers; synchronous reset wins over valid_in.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign S         = result_q.sum;
    assign C         = result_q.carry;
    assign valid_out = valid_q;

endmodule : full_adder_cascading

// File: tb/tb_full_adder_cascading.sv
// Directed and random checks of full_adder_cascading at WIDTH 1, 4, 8 and 16.
module tb_full_adder_cascading;

    logic clk = 1'b0;
    logic rst;
    logic valid_in;
    logic z;

    logic [0:0]  a1,  b1,  s1;
    logic [3:0]  a4,  b4,  s4;
    logic [7:0]  a8,  b8,  s8;
    logic [15:0] a16, b16, s16;
    logic        c1, c4, c8, c16;
    logic        v1, v4, v8, v16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

`ifdef FAC_CARRY_IN_EN
    full_adder_cascading #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(a1), .B(b1), .Z(z),
        .S(s1), .C(c1), .valid_out(v1));
    full_adder_cascading #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(a4), .B(b4), .Z(z),
        .S(s4), .C(c4), .valid_out(v4));
    full_adder_cascading #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(a8), .B(b8), .Z(z),
        .S(s8), .C(c8), .valid_out(v8));
    full_adder_cascading #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(a16), .B(b16), .Z(z),
        .S(s16), .C(c16), .valid_out(v16));
`else
    full_adder_cascading #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(a1), .B(b1),
        .S(s1), .C(c1), .valid_out(v1));
    full_adder_cascading #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(a4), .B(b4),
        .S(s4), .C(c4), .valid_out(v4));
    full_adder_cascading #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(a8), .B(b8),
        .S(s8), .C(c8), .valid_out(v8));
    full_adder_cascading #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(a16), .B(b16),
        .S(s16), .C(c16), .valid_out(v16));
`endif

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r);
        @(negedge clk);
        valid_in = v;
        rst      = r;
    endtask

    logic [16:0] exp16;

    initial begin
        rst = 1'b1; valid_in = 1'b0; z = 1'b0;
        a1 = '0; b1 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;

        // Reset applied with valid inputs present: outputs must stay cleared.
        drive(1'b1, 1'b1); a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'h1;
        tick();
        check("rst_s1", 65'(s1), 65'd0);
        check("rst_c1", 65'(c1), 65'd0);
        check("rst_v1", 65'(v1), 65'd0);
        check("rst_s4c4v4", 65'({c4, s4, v4}), 65'd0);
        check("rst_v16", 65'(v16), 65'd0);

        // WIDTH=1 sweep, with carry-propagation vectors on the wider instances.
        drive(1'b1, 1'b0); a1 = 1'b0; b1 = 1'b0; a4 = 4'hF; b4 = 4'h1;
        a8 = 8'hFF; b8 = 8'h01; a16 = 16'hFFFF; b16 = 16'h0001;
        tick();
        check("w1_00", 65'({c1, s1, v1}), 65'b001);
        check("w4_F_1", 65'({c4, s4}), 65'h10);
        check("w4_valid", 65'(v4), 65'd1);
        check("w8_FF_01", 65'({c8, s8}), 65'h100);
        check("w16_FFFF_1", 65'({c16, s16}), 65'h10000);

        drive(1'b1, 1'b0); a1 = 1'b0; b1 = 1'b1; a4 = 4'h7; b4 = 4'h8;
        a8 = 8'h5A; b8 = 8'hA5; a16 = 16'h1234; b16 = 16'h4321;
        tick();
        check("w1_01", 65'({c1, s1, v1}), 65'b011);
        check("w4_7_8", 65'({c4, s4}), 65'h0F);
        check("w8_5A_A5", 65'({c8, s8}), 65'h0FF);
        check("w16_1234_4321", 65'({c16, s16}), 65'h05555);

        drive(1'b1, 1'b0); a1 = 1'b1; b1 = 1'b0; a4 = 4'h9; b4 = 4'h9;
        a8 = 8'h80; b8 = 8'h80; a16 = 16'h8000; b16 = 16'h7FFF;
        tick();
        check("w1_10", 65'({c1, s1, v1}), 65'b011);
        check("w4_9_9", 65'({c4, s4}), 65'h12);
        check("w8_80_80", 65'({c8, s8}), 65'h100);
        check("w16_8000_7FFF", 65'({c16, s16}), 65'h0FFFF);

        drive(1'b1, 1'b0); a1 = 1'b1; b1 = 1'b1;
        tick();
        check("w1_11", 65'({c1, s1, v1}), 65'b101);

        // Hold: establish S=1,C=0 then idle three cycles with changing inputs.
        drive(1'b1, 1'b0); a1 = 1'b1; b1 = 1'b0; a4 = 4'h3; b4 = 4'h2;
        tick();
        check("hold_load", 65'({c1, s1, v1}), 65'b011);
        check("hold_load_w4", 65'({c4, s4}), 65'h05);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0); a1 = 1'(i); b1 = 1'(~i); a4 = 4'(i + 9); b4 = 4'hF;
            tick();
            check($sformatf("hold_w1_%0d", i), 65'({c1, s1, v1}), 65'b010);
            check($sformatf("hold_w4_%0d", i), 65'({c4, s4, v4}), 65'b0_0101_0);
        end

        // Reset in the middle of back-to-back valid traffic.
        drive(1'b1, 1'b0); a1 = 1'b1; b1 = 1'b1;
        tick();
        check("pre_rst", 65'({c1, s1, v1}), 65'b101);
        drive(1'b1, 1'b1); a1 = 1'b1; b1 = 1'b1;
        tick();
        check("mid_rst", 65'({c1, s1, v1}), 65'b000);
        drive(1'b0, 1'b0);
        tick();
        check("post_rst_idle", 65'({c1, s1, v1}), 65'b000);
        drive(1'b1, 1'b0); a1 = 1'b1; b1 = 1'b0;
        tick();
        check("post_rst_first", 65'({c1, s1, v1}), 65'b011);

`ifdef FAC_CARRY_IN_EN
        // Carry-in boundaries.
        drive(1'b1, 1'b0); z = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        a4 = 4'hF; b4 = 4'h0;
        tick();
        check("cin_w1_111", 65'({c1, s1}), 65'b11);
        check("cin_w8_FF_00", 65'({c8, s8}), 65'h100);
        check("cin_w4_F_0", 65'({c4, s4}), 65'h10);
        z = 1'b0;
`endif

        // Randomised WIDTH=16 vectors, one per cycle.
        for (int n = 0; n < 1000; n++) begin
            drive(1'b1, 1'b0);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
`ifdef FAC_CARRY_IN_EN
            z = 1'($urandom);
`endif
            exp16 = 17'(a16) + 17'(b16) + 17'(z);
            tick();
            check($sformatf("rand16_%0d", n), 65'({c16, s16}), 65'(exp16));
        end

        drive(1'b0, 1'b0);
        tick();
        check("final_idle_v16", 65'(v16), 65'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_full_adder_cascading
